// File: rtl/cache.sv
// ---------------------------------------------------------------------------
// cache
//   Direct-mapped, write-back, write-allocate data cache with an embedded
//   backing-memory model. It accepts single-word read, write and line-flush
//   requests from the core side and pulses req_done for one cycle when each
//   request completes.
//
//   Geometry: 16 lines of 4 x 32-bit words. Index = addr[7:4],
//   word = addr[3:2], tag = addr[31:8]. The memory is 1 KiB and is
//   addressed by addr[9:2], so upper address bits alias in memory.
//
// Ports
//   clk       in   1   clock, rising edge
//   reset     in   1   asynchronous reset, active low
//   req_addr  in   32  byte address (bits [1:0] ignored)
//   req_data  in   32  write data
//   req_type  in   2   00 read, 01 write, 10 flush line, 11 no-op
//   req_do    in   1   request strobe, sampled only in IDLE
//   O_data    out  32  last read result
//   req_done  out  1   one-cycle completion pulse
//
// States
//   S_IDLE      | waiting for req_do
//   S_LOOKUP    | tag compare; serve hits, decide on miss/flush handling
//   S_WRITEBACK | copying the dirty victim line to memory
//   S_FILL      | loading the requested line from memory
//   S_RESP      | req_done high for this cycle only
// ---------------------------------------------------------------------------
module cache #(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_type,
    input  logic        req_do,
    output logic [31:0] O_data,
    output logic        req_done
);

    localparam int NUM_LINES      = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int MEM_WORDS      = 256;
    localparam int MEM_LINES      = MEM_WORDS / WORDS_PER_LINE;
    localparam int LINE_W         = 32 * WORDS_PER_LINE;
    localparam int CNT_W          = $clog2(MEM_LATENCY + 1);

    localparam logic [1:0] T_READ  = 2'b00;
    localparam logic [1:0] T_WRITE = 2'b01;
    localparam logic [1:0] T_FLUSH = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_FILL,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [31:2]      addr_q;
    logic [31:0]      data_q;
    logic [1:0]       type_q;
    logic [CNT_W-1:0] cnt;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [23:0]          tag_q     [NUM_LINES];
    logic [LINE_W-1:0]    line_data [NUM_LINES];
    // Memory model starts out all zero; reset never touches it.
    logic [LINE_W-1:0]    mem       [MEM_LINES] = '{default: '0};

    logic [3:0]  idx;
    logic [1:0]  off;
    logic [23:0] tag_in;
    logic [5:0]  victim_line;
    logic        hit;
    logic        victim_dirty;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

    assign idx          = addr_q[7:4];
    assign off          = addr_q[3:2];
    assign tag_in       = addr_q[31:8];
    // Victim's memory line: low tag bits (addr[9:8]) above the index.
    assign victim_line  = {tag_q[idx][1:0], idx};
    assign hit          = valid_q[idx] && (tag_q[idx] == tag_in);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];

    assign req_done = (state == S_RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_do) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                case (type_q)
                    T_READ, T_WRITE: begin
                        if (hit)               state_nxt = S_RESP;
                        else if (victim_dirty) state_nxt = S_WRITEBACK;
                        else                   state_nxt = S_FILL;
                    end
                    T_FLUSH: begin
                        if (hit && dirty_q[idx]) state_nxt = S_WRITEBACK;
                        else                     state_nxt = S_RESP;
                    end
                    default: state_nxt = S_RESP;
                endcase
            end
            S_WRITEBACK: begin
                if (cnt == '0) state_nxt = (type_q == T_FLUSH) ? S_RESP : S_FILL;
            end
            S_FILL: begin
                if (cnt == '0) state_nxt = S_LOOKUP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control registers, valid/dirty bits and the read-data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            type_q  <= '0;
            cnt     <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            O_data  <= '0;
        end else begin
            if (state == S_IDLE && req_do) begin
                addr_q <= req_addr[31:2];
                data_q <= req_data;
                type_q <= req_type;
            end

            // Memory timer reloads on every state change, so WRITEBACK and
            // FILL each last exactly MEM_LATENCY cycles.
            if (state_nxt != state)
                cnt <= CNT_W'(MEM_LATENCY - 1);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;

            case (state)
                S_LOOKUP: begin
                    if (hit && type_q == T_READ)
                        O_data <= line_data[idx][{off, 5'd0} +: 32];
                    if (hit && type_q == T_WRITE)
                        dirty_q[idx] <= 1'b1;
                    if (hit && type_q == T_FLUSH && !dirty_q[idx])
                        valid_q[idx] <= 1'b0;
                end
                S_WRITEBACK: begin
                    if (cnt == '0) begin
                        dirty_q[idx] <= 1'b0;
                        if (type_q == T_FLUSH) valid_q[idx] <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (cnt == '0) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage arrays: not reset.
    always_ff @(posedge clk) begin
        if (state == S_LOOKUP && hit && type_q == T_WRITE)
            line_data[idx][{off, 5'd0} +: 32] <= data_q;
        if (state == S_FILL && cnt == '0) begin
            line_data[idx] <= mem[addr_q[9:4]];
            tag_q[idx]     <= tag_in;
        end
        if (state == S_WRITEBACK && cnt == '0)
            mem[victim_line] <= line_data[idx];
    end

endmodule

// File: tb/tb_cache.sv
module tb_cache;

    logic        clk;
    logic        reset;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_type;
    logic        req_do;
    logic [31:0] O_data;
    logic        req_done;

    int n_pass  = 0;
    int n_total = 0;

    cache dut (
        .clk      (clk),
        .reset    (reset),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_type (req_type),
        .req_do   (req_do),
        .O_data   (O_data),
        .req_done (req_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issues one request and returns its latency: cycles from the sampling
    // edge up to and including the req_done cycle (0 if it never completed).
    // Also confirms that req_done drops again after one cycle.
    task automatic run_req(input logic [1:0] t, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        req_type = t;
        req_addr = a;
        req_data = d;
        req_do   = 1'b1;
        @(posedge clk);
        #1;
        req_do   = 1'b0;
        req_addr = 32'hFFFF_FFF0;
        req_data = 32'hDEAD_BEEF;
        req_type = 2'b00;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (req_done) begin
                seen = 1'b1;
                lat  = k + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("done_pulse_width", {31'd0, req_done}, 32'd0);
    endtask

    int lat;
    bit done_seen;

    initial begin
        reset    = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_type = '0;
        req_do   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_odata", O_data, 32'd0);
        chk("reset_done", {31'd0, req_done}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Cold read miss.
        run_req(2'b00, 32'h0000_03FC, 32'h0, lat);
        chk("rd3fc_miss_lat", lat, 7);
        chk("rd3fc_miss_data", O_data, 32'h0);

        run_req(2'b00, 32'h0000_0200, 32'h0, lat);
        chk("rd200_miss_lat", lat, 7);
        run_req(2'b00, 32'h0000_0200, 32'h0, lat);
        chk("rd200_hit_lat", lat, 2);
        chk("rd200_hit_data", O_data, 32'h0);

        // Write hits, O_data must not move on writes.
        run_req(2'b01, 32'h0000_03FC, 32'hAABB_CCDD, lat);
        chk("wr3fc_hit_lat", lat, 2);
        chk("wr3fc_odata_kept", O_data, 32'h0);
        run_req(2'b01, 32'h0000_0200, 32'h1234_5678, lat);
        chk("wr200_hit_lat", lat, 2);
        run_req(2'b00, 32'h0000_03FC, 32'h0, lat);
        chk("rd3fc_hit_lat", lat, 2);
        chk("rd3fc_hit_data", O_data, 32'hAABB_CCDD);
        run_req(2'b00, 32'h0000_0200, 32'h0, lat);
        chk("rd200_hit2_lat", lat, 2);
        chk("rd200_hit2_data", O_data, 32'h1234_5678);

        // Reserved type and flush miss: quick no-ops.
        run_req(2'b11, 32'h0000_03FC, 32'h0, lat);
        chk("noop_lat", lat, 2);
        chk("noop_odata_kept", O_data, 32'h1234_5678);
        run_req(2'b10, 32'h0000_0700, 32'h0, lat);
        chk("flush_miss_lat", lat, 2);

        // Dirty flush writes back, then the line must be refetched.
        run_req(2'b10, 32'h0000_0200, 32'h0, lat);
        chk("flush_dirty_lat", lat, 6);
        chk("flush_odata_kept", O_data, 32'h1234_5678);
        run_req(2'b00, 32'h0000_0200, 32'h0, lat);
        chk("rd200_refetch_lat", lat, 7);
        chk("rd200_refetch_data", O_data, 32'h1234_5678);

        // Clean flush just invalidates.
        run_req(2'b10, 32'h0000_0200, 32'h0, lat);
        chk("flush_clean_lat", lat, 2);
        run_req(2'b00, 32'h0000_0200, 32'h0, lat);
        chk("rd200_after_inval_lat", lat, 7);

        // Dirty the 0x200 line, then evict it with 0x1200 (same index).
        run_req(2'b01, 32'h0000_0200, 32'h1234_5678, lat);
        chk("wr200_dirty_lat", lat, 2);
        run_req(2'b01, 32'h0000_1200, 32'h0000_0055, lat);
        chk("wr1200_dirty_miss_lat", lat, 11);
        chk("wr1200_odata_kept", O_data, 32'h1234_5678);
        // 0x1200 and 0x200 share memory bits [9:0], so they alias in memory:
        // evicting the dirty 0x1200 line leaves 0x55 in word 0x80.
        run_req(2'b00, 32'h0000_0200, 32'h0, lat);
        chk("rd200_dirty_miss_lat", lat, 11);
        chk("rd200_alias_data", O_data, 32'h0000_0055);

        // Reset in the middle of a fill.
        req_type = 2'b00;
        req_addr = 32'h0000_0100;
        req_do   = 1'b1;
        @(posedge clk);
        #1;
        req_do = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_odata", O_data, 32'h0);
        chk("midreset_done", {31'd0, req_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (req_done) done_seen = 1'b1;
        end
        chk("aborted_no_done", {31'd0, done_seen}, 32'd0);
        // Dirty 0xAABBCCDD in line 0xF was never written back: lost.
        run_req(2'b00, 32'h0000_03FC, 32'h0, lat);
        chk("rd3fc_post_reset_lat", lat, 7);
        chk("rd3fc_post_reset_data", O_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
